// File: rtl/fp_mult_out_pkg.sv
// Shared types and status-bit positions for the FP32 multiplier output stage.
// Optional counters are enabled by defining FP_MULT_OUT_STAGE_CNT_EN.
package fp_mult_out_pkg;

  localparam int STAT_ZERO    = 0;
  localparam int STAT_INF     = 1;
  localparam int STAT_NAN     = 2;
  localparam int STAT_TINY    = 3;
  localparam int STAT_HUGE    = 4;
  localparam int STAT_INEXACT = 5;

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  status;
  } mult_res_t;

endpackage : fp_mult_out_pkg

// File: rtl/fp_mult_out_fifo.sv
// Small synchronous FIFO of multiplier results with registered full/empty.
// Storage is reset so the head reads as zero until the first write.
module fp_mult_out_fifo
  import fp_mult_out_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  mult_res_t wdata_i,
  output mult_res_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  mult_res_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_s, pop_s;

  assign push_s  = push_i && !full_q;
  assign pop_s   = pop_i && !empty_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Flags are registered from the next count so in_ready/out_valid come straight off flops.
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule : fp_mult_out_fifo

// File: rtl/fp_mult_out_stage.sv
// Output stage of the FP32 multiplier: result FIFO, sticky exception flags and,
// when FP_MULT_OUT_STAGE_CNT_EN is defined, saturating per-status-bit event counters.
module fp_mult_out_stage
  import fp_mult_out_pkg::*;
#(
  parameter int         DEPTH     = 2,
  parameter logic [7:0] FLAG_MASK = 8'h3F,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_z,
  input  logic [7:0]       in_status,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_z,
  output logic [7:0]       out_status,
  input  logic             out_ready,
  input  logic             flags_clr,
  output logic [7:0]       flags,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_val
);

  mult_res_t  wdata_s, rdata_s;
  logic       full_s, empty_s;
  logic       push_s, pop_s;
  logic [7:0] flags_q, flags_d;

  assign wdata_s    = '{z: in_z, status: in_status};
  assign in_ready   = !full_s;
  assign out_valid  = !empty_s;
  assign out_z      = rdata_s.z;
  assign out_status = rdata_s.status;
  assign push_s     = in_valid && in_ready;
  assign pop_s      = out_valid && out_ready;
  assign flags      = flags_q;

  fp_mult_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wdata_s),
    .rdata_o (rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Clear is applied before the OR so bits pushed in the clearing cycle survive.
  always_comb begin
    flags_d = (flags_q & ~{8{flags_clr}}) | (push_s ? (in_status & FLAG_MASK) : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 8'h00;
    end else begin
      flags_q <= flags_d;
    end
  end

`ifdef FP_MULT_OUT_STAGE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [CNT_W-1:0] cnt_val_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = flags_clr ? '0 : cnt_q[i];
      if (push_s && in_status[i] && (cnt_d[i] != '1)) begin
        cnt_d[i] = cnt_d[i] + CNT_ONE;
      end else begin
        cnt_d[i] = cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_val_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cnt_val_q <= cnt_q[cnt_sel];
    end
  end

  assign cnt_val = cnt_val_q;
`else
  logic unused_cnt_sel_s;

  assign unused_cnt_sel_s = ^cnt_sel;
  assign cnt_val          = '0;
`endif

endmodule : fp_mult_out_stage
